morse_press_sequencer: RTL
==========================

# morse_press_sequencer

Controller that sequences the 9600 Hz tick counter of the Morse reader. It restarts the counter at every button edge and reads the elapsed tick count at each edge to time presses and gaps. It classifies each press as dot or dash, accumulates up to five symbols per letter, and flags letter and word boundaries. Its outputs feed the Morse-to-ASCII decoder.

## Interface
- DOT_MAX_TICKS, 2400: longest press classified as dot (250 ms); longer presses are dashes.
- MIN_PRESS_TICKS, 96: presses shorter than this (10 ms) are glitches and are discarded.
- LETTER_GAP_TICKS, 2400: release time that closes the current letter.
- WORD_GAP_TICKS, 6720: release time that closes the current word (700 ms).
- MAX_SYMS, 5: symbol capacity of one letter.
- clk  in  1  system clock, 25 MHz.
- rst_n  in  1  asynchronous active-low reset.
- btn  in  1  debounced Morse key level, 1 = pressed; asynchronous to clk.
- tick_count  in  17  elapsed ticks from the tick counter; 0 when idle; saturates at 96000.
- tick_start  out  1  run/clear control to the tick counter; 0 clears it.
- sym_valid  out  1  one-cycle pulse: a new symbol was accepted.
- sym_dash  out  1  qualified by sym_valid: 1 = dash, 0 = dot.
- letter_valid  out  1  one-cycle pulse: letter complete.
- letter_code  out  5  symbols of the letter, first symbol in the MSB-most used bit; valid with letter_valid.
- letter_len  out  3  symbol count 1..5; valid with letter_valid.
- letter_err  out  1  qualified by letter_valid: more than MAX_SYMS symbols were keyed.
- word_end  out  1  one-cycle pulse: word boundary.

## Operation
- btn passes through a 2-FF synchronizer, then a registered edge detector.
- Tick counter contract: tick_count is sampled in the first cycle that tick_start is low. The counter zeroes on the following edge.
- FSM states: IDLE, PRESS, CAPT_P, GAP, CAPT_G.
- IDLE: tick_start=0. A synchronized rise goes to PRESS.
- PRESS: tick_start=1. A synchronized fall goes to CAPT_P.
- CAPT_P: tick_start=0. The block latches tick_count as t.
  - t < MIN_PRESS_TICKS: discard, no output.
  - MIN_PRESS_TICKS ≤ t ≤ DOT_MAX_TICKS: dot.
  - t > DOT_MAX_TICKS: dash.
  - Next state is always GAP.
- Symbol accept: sym_valid=1 and sym_dash set in the cycle after CAPT_P.
  - len < MAX_SYMS: code = {code[3:0], dash} and len increments.
  - len = MAX_SYMS: code and len hold and the overflow flag sets.
- GAP: tick_start=1.
  - tick_count ≥ LETTER_GAP_TICKS with len > 0: letter_valid pulses once with code, len and err. The buffer then clears, and word_pending sets.
  - tick_count ≥ WORD_GAP_TICKS: word_end pulses if word_pending, which then clears. Next state IDLE.
  - Synchronized rise: go to CAPT_G.
- CAPT_G: one-cycle restart with tick_start=0, then PRESS. A letter still open (gap < LETTER_GAP_TICKS) continues to accumulate.
- A saturated tick_count (96000) reads as a dash in PRESS and as a word gap in GAP.

## Timing
- Reset values: all outputs 0; FSM in IDLE; code, len, overflow and word_pending all 0.
- rst_n low mid-press forces tick_start=0 immediately, which clears the tick counter. Any partial letter is lost.
- btn-to-FSM latency is 3 clk: 2 synchronizer stages plus the edge register.
- tick_start falls on the edge after the detected btn edge.
- sym_valid asserts 2 clk after CAPT_P is entered.
- letter_valid and word_end are registered pulses of exactly 1 clk.
- letter_valid and word_end never pulse in the same cycle. The letter is always emitted first, because LETTER_GAP_TICKS < WORD_GAP_TICKS.
- A button edge that arrives in CAPT_P or CAPT_G is held by the edge detector and acted on after the state completes. No edge is lost.

## Test plan
Bench uses a behavioural tick source: it increments tick_count every 2605 clk while tick_start=1, and zeroes it one cycle after tick_start falls.
- Press 1000 ticks, release > 6720 ticks → sym_valid with sym_dash=0; letter_valid with code=00000, len=1; then word_end.
- Dash-dot-dot: presses of 3000, 1000, 1000 ticks, 500-tick gaps → three sym_valid (1, 0, 0); one letter_valid with code=00100, len=3, err=0.
- Press of 50 ticks, then release > 6720 ticks → no sym_valid, no letter_valid, no word_end.
- Six 1000-tick presses with 500-tick gaps → five sym_valid with len=5; a sixth sym_valid; letter_valid with len=5, err=1.
- Two letters separated by a 3000-tick gap, then a 7000-tick gap → letter_valid twice; word_end once, after the second letter_valid.
- rst_n low during a 2000-tick press → tick_start=0 immediately; no outputs after release; next press classified normally.

Source files
------------

// File: rtl/morse_press_sequencer.sv
// Morse key press sequencer: drives the tick counter, times presses and gaps,
// classifies dot/dash, collects up to MAX_SYMS symbols per letter and flags
// letter and word boundaries for the downstream decoder.
module morse_press_sequencer #(
    parameter int unsigned DOT_MAX_TICKS    = 2400,
    parameter int unsigned MIN_PRESS_TICKS  = 96,
    parameter int unsigned LETTER_GAP_TICKS = 2400,
    parameter int unsigned WORD_GAP_TICKS   = 6720,
    parameter int unsigned MAX_SYMS         = 5
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        btn,
    input  logic [16:0] tick_count,
    output logic        tick_start,
    output logic        sym_valid,
    output logic        sym_dash,
    output logic        letter_valid,
    output logic [4:0]  letter_code,
    output logic [2:0]  letter_len,
    output logic        letter_err,
    output logic        word_end
);

    localparam int unsigned TICK_W = 17;
    localparam int unsigned CODE_W = 5;
    localparam int unsigned LEN_W  = 3;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        PRESS  = 3'd1,
        CAPT_P = 3'd2,
        GAP    = 3'd3,
        CAPT_G = 3'd4
    } state_t;

    state_t              state_q, state_n;

    logic                btn_s1, btn_s2, btn_prev;
    logic [1:0]          arm_cnt;
    logic                armed_c, hold_c;
    logic                rise_q, fall_q;

    logic                acc_pend_q, acc_pend_n;
    logic                acc_dash_q, acc_dash_n;
    logic [CODE_W-1:0]   code_q, code_n;
    logic [LEN_W-1:0]    len_q, len_n;
    logic                err_q, err_n;
    logic                wpend_q, wpend_n;

    logic                tick_start_n;
    logic                sym_valid_n, sym_dash_n;
    logic                letter_valid_n, letter_err_n, word_end_n;
    logic [CODE_W-1:0]   letter_code_n;
    logic [LEN_W-1:0]    letter_len_n;

    // Edges are only trusted once the synchronizer holds post-reset samples,
    // so a key held through reset does not produce a phantom press.
    assign armed_c = (arm_cnt == 2'd3);
    // Capture states are single-cycle; edges seen there are held for the next state.
    assign hold_c  = (state_q == CAPT_P) || (state_q == CAPT_G);

    // Two-stage synchronizer plus registered, holdable edge detector
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            btn_s1   <= 1'b0;
            btn_s2   <= 1'b0;
            btn_prev <= 1'b0;
            arm_cnt  <= 2'd0;
            rise_q   <= 1'b0;
            fall_q   <= 1'b0;
        end else begin
            btn_s1   <= btn;
            btn_s2   <= btn_s1;
            btn_prev <= btn_s2;
            if (!armed_c) begin
                arm_cnt <= arm_cnt + 2'd1;
            end
            rise_q <= (armed_c & btn_s2 & ~btn_prev) | (hold_c & rise_q);
            fall_q <= (armed_c & ~btn_s2 & btn_prev) | (hold_c & fall_q);
        end
    end

    // Next-state, symbol buffer and output logic
    always_comb begin
        state_n        = state_q;
        acc_pend_n     = 1'b0;
        acc_dash_n     = acc_dash_q;
        code_n         = code_q;
        len_n          = len_q;
        err_n          = err_q;
        wpend_n        = wpend_q;
        sym_valid_n    = 1'b0;
        sym_dash_n     = sym_dash;
        letter_valid_n = 1'b0;
        letter_code_n  = letter_code;
        letter_len_n   = letter_len;
        letter_err_n   = letter_err;
        word_end_n     = 1'b0;

        // Accept the symbol classified in the previous (capture) cycle
        if (acc_pend_q) begin
            sym_valid_n = 1'b1;
            sym_dash_n  = acc_dash_q;
            if (len_q < LEN_W'(MAX_SYMS)) begin
                code_n = {code_q[CODE_W-2:0], acc_dash_q};
                len_n  = len_q + LEN_W'(1);
            end else begin
                err_n  = 1'b1;
            end
        end

        unique case (state_q)
            IDLE: begin
                if (rise_q) state_n = PRESS;
            end
            PRESS: begin
                if (fall_q) state_n = CAPT_P;
            end
            CAPT_P: begin
                acc_pend_n = (tick_count >= TICK_W'(MIN_PRESS_TICKS));
                acc_dash_n = (tick_count >  TICK_W'(DOT_MAX_TICKS));
                state_n    = GAP;
            end
            GAP: begin
                // Letter closes strictly before the word, so len is empty at word time
                if (!acc_pend_q && (len_q != '0) &&
                    (tick_count >= TICK_W'(LETTER_GAP_TICKS))) begin
                    letter_valid_n = 1'b1;
                    letter_code_n  = code_q;
                    letter_len_n   = len_q;
                    letter_err_n   = err_q;
                    code_n         = '0;
                    len_n          = '0;
                    err_n          = 1'b0;
                    wpend_n        = 1'b1;
                end else if (tick_count >= TICK_W'(WORD_GAP_TICKS)) begin
                    word_end_n = wpend_q;
                    wpend_n    = 1'b0;
                    state_n    = IDLE;
                end
                if (rise_q) state_n = CAPT_G;
            end
            CAPT_G: begin
                state_n = PRESS;
            end
            default: begin
                state_n = IDLE;
            end
        endcase

        tick_start_n = (state_n == PRESS) || (state_n == GAP);
    end

    // State, buffer and registered outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            acc_pend_q   <= 1'b0;
            acc_dash_q   <= 1'b0;
            code_q       <= '0;
            len_q        <= '0;
            err_q        <= 1'b0;
            wpend_q      <= 1'b0;
            tick_start   <= 1'b0;
            sym_valid    <= 1'b0;
            sym_dash     <= 1'b0;
            letter_valid <= 1'b0;
            letter_code  <= '0;
            letter_len   <= '0;
            letter_err   <= 1'b0;
            word_end     <= 1'b0;
        end else begin
            state_q      <= state_n;
            acc_pend_q   <= acc_pend_n;
            acc_dash_q   <= acc_dash_n;
            code_q       <= code_n;
            len_q        <= len_n;
            err_q        <= err_n;
            wpend_q      <= wpend_n;
            tick_start   <= tick_start_n;
            sym_valid    <= sym_valid_n;
            sym_dash     <= sym_dash_n;
            letter_valid <= letter_valid_n;
            letter_code  <= letter_code_n;
            letter_len   <= letter_len_n;
            letter_err   <= letter_err_n;
            word_end     <= word_end_n;
        end
    end

endmodule
